// File: rtl/conv_disp_pkg.sv
// conv_disp_pkg: shared types and constants for the convolution result display.
//   state_e      - display FSM states
//   SEG_0..SEG_9 - seven-segment codes, bits [6:0] = g..a, active-high
//   MAX_DISPLAY  - largest value shown before saturating
//   BCD_SHIFTS   - double-dabble iterations for a 7-bit binary value
`timescale 1ns/1ps
package conv_disp_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONVERT   = 3'd1,
    SHOW_TENS = 3'd2,
    GAP_TENS  = 3'd3,
    SHOW_ONES = 3'd4,
    GAP_ONES  = 3'd5
  } state_e;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam int MAX_DISPLAY = 99;
  localparam int BCD_SHIFTS  = 7;

endpackage

// File: rtl/conv_result_display_seg7_decode.sv
// seg7_decode: combinational BCD digit to seven-segment pattern.
//   bcd_i [3:0] in  - BCD digit; codes 10..15 produce a blank pattern
//   seg_o [6:0] out - segments g..a, active-high
`timescale 1ns/1ps
module seg7_decode
  import conv_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/conv_result_display.sv
// conv_result_display: captures the convolution sum, saturates it to 0..99,
// converts it to BCD with a 7-cycle double-dabble engine and cycles one
// seven-segment display through tens / blank / ones / blank.
//   clk        in  - system clock
//   rst_n      in  - asynchronous reset, active-high
//   data_in    in  - unsigned convolution sum, sampled on data_valid
//   data_valid in  - one-cycle strobe for data_in
//   busy       out - high while converting
//   bcd_out    out - {tens, ones} of the displayed value
//   bcd_valid  out - one-cycle pulse when bcd_out updates
//   overflow   out - captured value exceeded 99
//   seg_out    out - [6:0] segments g..a, [7] decimal point = overflow
`timescale 1ns/1ps
module conv_result_display
  import conv_disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 10_000_000,
  parameter int BLANK_CYCLES = 2_000_000,
  parameter int IN_W         = 36
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] data_in,
  input  logic            data_valid,
  output logic            busy,
  output logic [7:0]      bcd_out,
  output logic            bcd_valid,
  output logic            overflow,
  output logic [7:0]      seg_out
);

  localparam int MAX_DWELL = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W     = $clog2(MAX_DWELL + 1);
  localparam logic [CNT_W-1:0] DIGIT_LOAD = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [2:0]       shcnt_q, shcnt_d;
  logic [6:0]       bin_q, bin_d;
  logic [7:0]       work_q, work_d;
  logic [7:0]       bcd_out_q, bcd_out_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic [7:0]       seg_q, seg_d;

  logic [7:0]       adj;
  logic [14:0]      shifted;
  logic             capture;
  logic [6:0]       seg_tens, seg_ones;

  seg7_decode u_dec_tens (.bcd_i(bcd_out_d[7:4]), .seg_o(seg_tens));
  seg7_decode u_dec_ones (.bcd_i(bcd_out_d[3:0]), .seg_o(seg_ones));

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    shcnt_d     = shcnt_q;
    bin_d       = bin_q;
    work_d      = work_q;
    bcd_out_d   = bcd_out_q;
    bcd_valid_d = 1'b0;
    overflow_d  = overflow_q;

    // One double-dabble step: correct nibbles >= 5, then shift left.
    adj = work_q;
    if (work_q[3:0] >= 4'd5) adj[3:0] = work_q[3:0] + 4'd3;
    if (work_q[7:4] >= 4'd5) adj[7:4] = work_q[7:4] + 4'd3;
    shifted = {adj, bin_q} << 1;

    // A strobe outside CONVERT always restarts, even on a dwell expiry cycle.
    capture = data_valid && (state_q != CONVERT);

    case (state_q)
      CONVERT: begin
        work_d  = shifted[14:7];
        bin_d   = shifted[6:0];
        shcnt_d = shcnt_q + 3'd1;
        if (shcnt_q == 3'(BCD_SHIFTS - 1)) begin
          shcnt_d     = 3'd0;
          bcd_out_d   = shifted[14:7];
          bcd_valid_d = 1'b1;
          dwell_d     = DIGIT_LOAD;
          state_d     = (shifted[14:11] == 4'd0) ? SHOW_ONES : SHOW_TENS;
        end
      end
      SHOW_TENS, SHOW_ONES, GAP_TENS, GAP_ONES: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - 1'b1;
        end else begin
          case (state_q)
            SHOW_TENS: begin state_d = GAP_TENS; dwell_d = BLANK_LOAD; end
            GAP_TENS:  begin state_d = SHOW_ONES; dwell_d = DIGIT_LOAD; end
            SHOW_ONES: begin state_d = GAP_ONES; dwell_d = BLANK_LOAD; end
            default: begin
              state_d = (bcd_out_q[7:4] == 4'd0) ? SHOW_ONES : SHOW_TENS;
              dwell_d = DIGIT_LOAD;
            end
          endcase
        end
      end
      default: ;
    endcase

    if (capture) begin
      state_d    = CONVERT;
      dwell_d    = '0;
      shcnt_d    = 3'd0;
      work_d     = 8'h00;
      overflow_d = (data_in > IN_W'(MAX_DISPLAY));
      bin_d      = overflow_d ? 7'(MAX_DISPLAY) : data_in[6:0];
    end

    busy_d = (state_d == CONVERT);

    // Outputs are registered from the next state so they change with it.
    case (state_d)
      SHOW_TENS:          seg_d = {overflow_d, seg_tens};
      SHOW_ONES:          seg_d = {overflow_d, seg_ones};
      GAP_TENS, GAP_ONES: seg_d = {overflow_d, 7'h00};
      default:            seg_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      dwell_q     <= '0;
      shcnt_q     <= 3'd0;
      bin_q       <= 7'h00;
      work_q      <= 8'h00;
      bcd_out_q   <= 8'h00;
      bcd_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      seg_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      shcnt_q     <= shcnt_d;
      bin_q       <= bin_d;
      work_q      <= work_d;
      bcd_out_q   <= bcd_out_d;
      bcd_valid_q <= bcd_valid_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      seg_q       <= seg_d;
    end
  end

  assign busy      = busy_q;
  assign bcd_out   = bcd_out_q;
  assign bcd_valid = bcd_valid_q;
  assign overflow  = overflow_q;
  assign seg_out   = seg_q;

endmodule

// File: tb/tb_conv_result_display.sv
`timescale 1ns/1ps
module tb_conv_result_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [35:0] data_in;
  logic        data_valid;
  logic        busy;
  logic [7:0]  bcd_out;
  logic        bcd_valid;
  logic        overflow;
  logic [7:0]  seg_out;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] last_bcd = 8'h00;

  conv_result_display #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2), .IN_W(36)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .busy(busy), .bcd_out(bcd_out), .bcd_valid(bcd_valid),
    .overflow(overflow), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected seg_out c cycles after the first digit frame.
  function automatic logic [7:0] exp_seg(int c, logic [7:0] t, logic [7:0] o,
                                         logic [7:0] gap, bit show_tens);
    int p;
    if (show_tens) begin
      p = c % 12;
      if (p < 4) return t;
      if (p < 6) return gap;
      if (p < 10) return o;
      return gap;
    end
    p = c % 6;
    return (p < 4) ? o : gap;
  endfunction

  // Strobe v at the current cycle, optionally strobe inj at cycle inj_at
  // (inside CONVERT), then verify the 7 busy cycles and the result cycle.
  task automatic convert_check(input logic [35:0] v, input logic [7:0] e_bcd,
                               input logic e_ovf, input logic [7:0] e_seg,
                               input int inj_at, input logic [35:0] inj, input string name);
    data_in = v; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tests_run++;
      if (busy !== 1'b1 || bcd_valid !== 1'b0 || seg_out !== 8'h00 || bcd_out !== last_bcd) begin
        tests_failed++;
        $display("FAIL %s conv cyc%0d: busy=%b vld=%b seg=%h bcd=%h, want busy=1 vld=0 seg=00 bcd=%h",
                 name, c, busy, bcd_valid, seg_out, bcd_out, last_bcd);
      end
      if (c == inj_at) begin data_in = inj; data_valid = 1'b1; end
      tick();
      data_valid = 1'b0;
    end
    tests_run++;
    if (busy !== 1'b0 || bcd_valid !== 1'b1 || bcd_out !== e_bcd || overflow !== e_ovf || seg_out !== e_seg) begin
      tests_failed++;
      $display("FAIL %s result: busy=%b vld=%b bcd=%h ovf=%b seg=%h, want 0 1 %h %b %h",
               name, busy, bcd_valid, bcd_out, overflow, seg_out, e_bcd, e_ovf, e_seg);
    end
    last_bcd = e_bcd;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; data_valid = 1'b0; data_in = '0;
    tick(); tick();
    tests_run++;
    if (seg_out !== 8'h00 || bcd_out !== 8'h00 || bcd_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: seg=%h bcd=%h vld=%b busy=%b ovf=%b, want all 0",
               seg_out, bcd_out, bcd_valid, busy, overflow);
    end
    data_in = 36'd50; data_valid = 1'b1;
    tick();
    data_valid = 1'b0; rst_n = 1'b0;
    tick(); tick();
    tests_run++;
    if (busy !== 1'b0 || seg_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b seg=%h, want 0 00", busy, seg_out);
    end
  endtask

  task automatic test_basic_36();
    convert_check(36'd36, 8'h36, 1'b0, 8'h4F, 0, '0, "val36");
    for (int c = 0; c < 24; c++) begin
      tests_run++;
      if (seg_out !== exp_seg(c, 8'h4F, 8'h7D, 8'h00, 1'b1) || (c > 0 && bcd_valid !== 1'b0)) begin
        tests_failed++;
        $display("FAIL val36 loop c%0d: seg=%h vld=%b, want seg=%h vld=%b",
                 c, seg_out, bcd_valid, exp_seg(c, 8'h4F, 8'h7D, 8'h00, 1'b1), c == 0);
      end
      tick();
    end
  endtask

  task automatic test_suppress_7();
    convert_check(36'd7, 8'h07, 1'b0, 8'h07, 0, '0, "val7");
    for (int c = 0; c < 18; c++) begin
      tests_run++;
      if (seg_out !== exp_seg(c, 8'h00, 8'h07, 8'h00, 1'b0)) begin
        tests_failed++;
        $display("FAIL val7 loop c%0d: seg=%h, want %h", c, seg_out, exp_seg(c, 8'h00, 8'h07, 8'h00, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_overflow_150();
    convert_check(36'd150, 8'h99, 1'b1, 8'hEF, 0, '0, "val150");
    for (int c = 0; c < 24; c++) begin
      tests_run++;
      if (seg_out !== exp_seg(c, 8'hEF, 8'hEF, 8'h80, 1'b1)) begin
        tests_failed++;
        $display("FAIL val150 loop c%0d: seg=%h, want %h", c, seg_out, exp_seg(c, 8'hEF, 8'hEF, 8'h80, 1'b1));
      end
      tick();
    end
  endtask

  task automatic test_boundary();
    convert_check(36'd99, 8'h99, 1'b0, 8'h6F, 0, '0, "val99");
    tick(); tick();
    convert_check(36'd100, 8'h99, 1'b1, 8'hEF, 0, '0, "val100");
    tick();
    // Low bits alone would read as 5: saturation must look at the full width.
    convert_check(36'h8_0000_0005, 8'h99, 1'b1, 8'hEF, 0, '0, "val_wide");
    tick(); tick(); tick();
    convert_check(36'd58, 8'h58, 1'b0, 8'h6D, 0, '0, "val58");
    tick();
  endtask

  task automatic test_ignore_and_restart();
    convert_check(36'd12, 8'h12, 1'b0, 8'h06, 3, 36'd30, "val12_ignore");
    for (int c = 0; c < 6; c++) tick();
    tests_run++;
    if (seg_out !== 8'h5B || bcd_out !== 8'h12) begin
      tests_failed++;
      $display("FAIL val12 ones: seg=%h bcd=%h, want 5b 12", seg_out, bcd_out);
    end
    convert_check(36'd30, 8'h30, 1'b0, 8'h4F, 0, '0, "restart30");
    tick();
  endtask

  task automatic test_gap_expiry();
    convert_check(36'd45, 8'h45, 1'b0, 8'h66, 0, '0, "val45");
    for (int c = 0; c < 11; c++) begin
      tests_run++;
      if (seg_out !== exp_seg(c, 8'h66, 8'h6D, 8'h00, 1'b1)) begin
        tests_failed++;
        $display("FAIL val45 loop c%0d: seg=%h, want %h", c, seg_out, exp_seg(c, 8'h66, 8'h6D, 8'h00, 1'b1));
      end
      tick();
    end
    // Last GAP_ONES cycle: strobe now, CONVERT must follow with no digit frame.
    convert_check(36'd81, 8'h81, 1'b0, 8'h7F, 0, '0, "gap_expiry81");
    tick();
  endtask

  task automatic test_reset_mid_convert();
    data_in = 36'd150; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (seg_out !== 8'h00 || bcd_out !== 8'h00 || bcd_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: seg=%h bcd=%h vld=%b busy=%b ovf=%b, want all 0",
               seg_out, bcd_out, bcd_valid, busy, overflow);
    end
    tick();
    rst_n = 1'b0;
    last_bcd = 8'h00;
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (busy !== 1'b0 || bcd_valid !== 1'b0 || seg_out !== 8'h00 || bcd_out !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_mid idle c%0d: busy=%b vld=%b seg=%h bcd=%h, want 0 0 00 00",
                 c, busy, bcd_valid, seg_out, bcd_out);
      end
      tick();
    end
    convert_check(36'd0, 8'h00, 1'b0, 8'h3F, 0, '0, "val0");
    for (int c = 0; c < 12; c++) begin
      tests_run++;
      if (seg_out !== exp_seg(c, 8'h00, 8'h3F, 8'h00, 1'b0)) begin
        tests_failed++;
        $display("FAIL val0 loop c%0d: seg=%h, want %h", c, seg_out, exp_seg(c, 8'h00, 8'h3F, 8'h00, 1'b0));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_36();
    test_suppress_7();
    test_overflow_150();
    test_boundary();
    test_ignore_and_restart();
    test_gap_expiry();
    test_reset_mid_convert();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
